// File: rtl/lab3_disp_pkg.sv
// Shared constants for the lab3 seven-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package lab3_disp_pkg;

  typedef logic [1:0] pos_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'h3F;

  // Standard hex glyphs, entry 15 first so HEX_GLYPH[v] is the glyph for v.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Display positions, 3 is the leftmost digit.
  localparam pos_t POS_DIGIT1 = 2'd3;
  localparam pos_t POS_DIGIT0 = 2'd2;
  localparam pos_t POS_COUNT1 = 2'd1;
  localparam pos_t POS_COUNT0 = 2'd0;

  // Decimal point separates the digit pair from the count pair.
  localparam pos_t DP_POS = 2'd2;

endpackage

// File: rtl/lab3_seg_decode.sv
// Combinational field-to-segment decoder.
//   field : 8-bit value; 0x00..0x0F shown as a hex glyph, anything larger as a dash
//   seg   : segments {g,f,e,d,c,b,a}, active low
module lab3_seg_decode
  import lab3_disp_pkg::*;
(
  input  logic [7:0] field,
  output logic [6:0] seg
);

  always_comb begin
    if (field[7:4] != 4'h0) begin
      seg = SEG_DASH;
    end else begin
      seg = HEX_GLYPH[field[3:0]];
    end
  end

endmodule

// File: rtl/lab3_seg_scan.sv
// Time-multiplexed 4-digit common-anode display driver for the lab3 classifier.
// Takes a snapshot of the four fields once per scan frame and blinks the display
// for WARN_HOLD frames after the last cycle with warning high.
//   CLK        : system clock, rising edge
//   clear      : synchronous active-high reset
//   digit1..count0 : upstream fields for positions 3..0
//   warning    : upstream warning level
//   an         : anode enables, active low
//   seg        : segments {g,f,e,d,c,b,a}, active low
//   dp         : decimal point, active low
//   frame_done : one-cycle pulse after each complete 4-position scan
module lab3_seg_scan
  import lab3_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4,
  parameter int unsigned BLINK_DIV   = 2,
  parameter int unsigned WARN_HOLD   = 8
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic [7:0] digit1,
  input  logic [7:0] digit0,
  input  logic [7:0] count1,
  input  logic [7:0] count0,
  input  logic       warning,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned DivW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned WarnW  = $clog2(WARN_HOLD + 1);

  logic [DivW-1:0]   div_q, div_d;
  pos_t              pos_q, pos_d;
  logic [3:0][7:0]   snap_q, snap_d;
  logic [WarnW-1:0]  warn_q, warn_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;

  logic       div_tc;
  logic       frame_tick;
  logic       blank;
  logic [6:0] seg_raw;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign div_tc     = (div_q == DivW'(REFRESH_DIV - 1));
  assign frame_tick = div_tc && (pos_q == POS_COUNT0);
  assign blank      = (warn_q != '0) && blink_ph_q;

  lab3_seg_decode u_decode (
    .field (snap_q[pos_q]),
    .seg   (seg_raw)
  );

  // Next-state logic for scan, snapshot, warn hold and blink.
  always_comb begin
    div_d       = div_tc ? '0 : div_q + DivW'(1);
    pos_d       = div_tc ? pos_q - 2'd1 : pos_q;  // 0 wraps naturally to 3
    snap_d      = frame_tick ? {digit1, digit0, count1, count0} : snap_q;

    warn_d = warn_q;
    if (warning) begin
      warn_d = WarnW'(WARN_HOLD);
    end else if (frame_tick && (warn_q != '0)) begin
      warn_d = warn_q - WarnW'(1);
    end

    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (warn_q == '0) begin
      // Idle: park in the visible phase so the next sequence starts visible.
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Output decode; registered below, so outputs lag pos/snapshot by one cycle.
  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(4'b0001 << pos_q);
      seg_d = seg_raw;
      dp_d  = (pos_q != DP_POS);
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      div_q       <= '0;
      pos_q       <= POS_DIGIT1;
      snap_q      <= '0;
      warn_q      <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      an          <= 4'hF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      div_q       <= div_d;
      pos_q       <= pos_d;
      snap_q      <= snap_d;
      warn_q      <= warn_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_done  <= frame_tick;
    end
  end

endmodule

// File: tb/tb_lab3_seg_scan.sv
module tb_lab3_seg_scan;

  localparam int unsigned R = 4;
  localparam int unsigned B = 2;
  localparam int unsigned H = 8;

  logic       CLK = 1'b0;
  logic       clear = 1'b1;
  logic [7:0] digit1 = '0, digit0 = '0, count1 = '0, count0 = '0;
  logic       warning = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done;

  int checks = 0;
  int failures = 0;

  // Reference model: cycles since release, frame ticks since the last warning
  // and since the start of the current warning episode.
  int         n;
  int         ticks_w;
  int         ticks_s;
  bit         seen;
  logic [7:0] m_snap [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_fd;

  lab3_seg_scan #(
    .REFRESH_DIV (R),
    .BLINK_DIV   (B),
    .WARN_HOLD   (H)
  ) dut (
    .CLK        (CLK),
    .clear      (clear),
    .digit1     (digit1),
    .digit0     (digit0),
    .count1     (count1),
    .count0     (count0),
    .warning    (warning),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] glyph(input logic [7:0] f);
    if (f[7:4] != 4'h0) return 7'h3F;
    case (f[3:0])
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // One clock edge: update the model with the inputs seen at the edge, then
  // step 1 time unit past the edge so the DUT outputs can be sampled.
  task automatic cycle();
    int p;
    bit act, blk, tk;
    @(posedge CLK);
    if (clear) begin
      n = 0; seen = 0; ticks_w = 0; ticks_s = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 8'h00;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      p   = 3 - ((n / R) % 4);
      act = seen && (ticks_w < H);
      blk = act && (((ticks_s / B) % 2) == 1);
      e_an  = blk ? 4'hF : (4'hF & ~(4'd1 << p));
      e_seg = blk ? 7'h7F : glyph(m_snap[p]);
      e_dp  = blk ? 1'b1 : (p != 2);
      n++;
      tk   = (n % (4 * R)) == 0;
      e_fd = tk;
      if (tk) begin
        m_snap[3] = digit1; m_snap[2] = digit0; m_snap[1] = count1; m_snap[0] = count0;
      end
      if (warning) begin
        if (!act) ticks_s = 0;
        else if (tk) ticks_s++;
        ticks_w = 0;
        seen    = 1;
      end else if (tk && act) begin
        ticks_w++;
        ticks_s++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int  k;
    bit  got;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold: an=%b seg=%h dp=%b fd=%b want 1111/7f/1/0",
                 an, seg, dp, frame_done);
      end
    end
    clear = 1'b0;
    got = 0;
    k = 0;
    while (!got && k < 40) begin
      cycle();
      k++;
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL reset_model: an=%b seg=%h dp=%b fd=%b want %b/%h/%b/%b",
                 an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (frame_done === 1'b1) got = 1;
    end
    checks++;
    if (!got || k != 16) begin
      failures++;
      $display("FAIL first_frame_done: seen after %0d cycles (found=%0d) want 16", k, got);
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] an_t  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] seg_t [4] = '{7'h21, 7'h24, 7'h30, 7'h78};
    logic       dp_w;
    digit1 = 8'h0D; digit0 = 8'h02; count1 = 8'h03; count0 = 8'h07;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) cycle();
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL scan_fd: frame_done=%b want 1", frame_done);
    end
    for (int k = 0; k < 16; k++) begin
      cycle();
      dp_w = ((k / 4) == 1) ? 1'b0 : 1'b1;
      checks++;
      if ({an, seg, dp} !== {an_t[k/4], seg_t[k/4], dp_w}) begin
        failures++;
        $display("FAIL scan_order[%0d]: an=%b seg=%h dp=%b want %b/%h/%b",
                 k, an, seg, dp, an_t[k/4], seg_t[k/4], dp_w);
      end
    end
  endtask

  task automatic test_snapshot();
    int fds;
    for (int i = 0; i < 6; i++) cycle();
    digit1 = 8'h05;
    fds = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL snapshot_model: an=%b seg=%h dp=%b fd=%b want %b/%h/%b/%b",
                 an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (an === 4'b0111) begin
        checks++;
        if (seg !== ((fds == 0) ? 7'h21 : 7'h12)) begin
          failures++;
          $display("FAIL snapshot_pos3: seg=%h want %h", seg, (fds == 0) ? 7'h21 : 7'h12);
        end
      end
      if (frame_done === 1'b1) fds++;
    end
  endtask

  task automatic test_out_of_range();
    int fds;
    count0 = 8'h1A;
    fds = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL range_model: an=%b seg=%h dp=%b fd=%b want %b/%h/%b/%b",
                 an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (fds > 0 && an === 4'b1110) begin
        checks++;
        if (seg !== 7'h3F) begin
          failures++;
          $display("FAIL range_dash: seg=%h want 3f", seg);
        end
      end
      if (frame_done === 1'b1) fds++;
    end
  endtask

  task automatic test_warning();
    int blanks;
    // Single pulse: two blanked windows of two frames each.
    warning = 1'b1;
    cycle();
    warning = 1'b0;
    blanks = 0;
    for (int i = 0; i < 12 * 16; i++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL warn_model: an=%b seg=%h dp=%b fd=%b want %b/%h/%b/%b",
                 an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (an === 4'hF) blanks++;
    end
    checks++;
    if (blanks != 64) begin
      failures++;
      $display("FAIL warn_single_blank_cycles: got %0d want 64", blanks);
    end
    // Second pulse five frames in restarts the hold: three blanked windows.
    warning = 1'b1;
    cycle();
    warning = 1'b0;
    blanks = 0;
    for (int i = 0; i < 80 + 16 * 16; i++) begin
      if (i == 80) warning = 1'b1;
      cycle();
      warning = 1'b0;
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL warn_restart_model: an=%b seg=%h dp=%b fd=%b want %b/%h/%b/%b",
                 an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (an === 4'hF) blanks++;
    end
    checks++;
    if (blanks != 96) begin
      failures++;
      $display("FAIL warn_restart_blank_cycles: got %0d want 96", blanks);
    end
  endtask

  task automatic test_clear_mid();
    int fds, k, blanks;
    warning = 1'b1;
    cycle();
    warning = 1'b0;
    fds = 0;
    k = 0;
    while (fds < 3 && k < 100) begin
      cycle();
      k++;
      if (frame_done === 1'b1) fds++;
    end
    cycle();
    cycle();
    checks++;
    if (fds != 3 || an !== 4'hF) begin
      failures++;
      $display("FAIL clear_mid_blanking: frames=%0d an=%b want 3/1111", fds, an);
    end
    digit1 = 8'h00; digit0 = 8'h00; count1 = 8'h00; count0 = 8'h00;
    clear = 1'b1;
    cycle();
    checks++;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL clear_mid_reset: an=%b seg=%h dp=%b fd=%b want 1111/7f/1/0",
               an, seg, dp, frame_done);
    end
    clear = 1'b0;
    blanks = 0;
    for (int i = 0; i < 12 * 16; i++) begin
      cycle();
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL clear_mid_model: an=%b seg=%h dp=%b fd=%b want %b/%h/%b/%b",
                 an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (an === 4'hF) blanks++;
    end
    checks++;
    if (blanks != 0) begin
      failures++;
      $display("FAIL clear_mid_no_blink: blank cycles=%0d want 0", blanks);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      digit1  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      digit0  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      count1  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      count0  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      warning = ($urandom_range(0, 149) == 0);
      cycle();
      checks++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL random_model[%0d]: an=%b seg=%h dp=%b fd=%b want %b/%h/%b/%b",
                 i, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
    warning = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_snapshot();
    test_out_of_range();
    test_warning();
    test_clear_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lab3_seg_scan.md
Name: lab3_seg_scan

Overview:
Display stage directly downstream of the lab3 prime/non-prime classifier. It consumes that block's digit1/digit0/count1/count0/warning outputs and drives a time-multiplexed 4-digit common-anode seven-segment display. It latches a tear-free snapshot of the fields once per scan frame and blinks the display for a fixed number of frames after any warning.

Parameters:
REFRESH_DIV, 4, clock cycles each digit position is held; legal range ≥1.
BLINK_DIV, 2, scan frames per blink half-period; legal range ≥1.
WARN_HOLD, 8, scan frames the display keeps blinking after the last cycle with warning=1; legal range ≥1.

Ports:
CLK  in  1  single system clock; all state updates on its rising edge.
clear  in  1  synchronous, active-high reset.
digit1  in  8  upstream field shown at position 3 (leftmost).
digit0  in  8  upstream field shown at position 2.
count1  in  8  upstream field shown at position 1.
count0  in  8  upstream field shown at position 0 (rightmost).
warning  in  1  upstream warning level, sampled every cycle.
an  out  4  anode enables, active low, one-hot-low or all-high.
seg  out  7  segments {g,f,e,d,c,b,a}, active low.
dp  out  1  decimal point, active low.
frame_done  out  1  one-cycle pulse at the end of each full 4-position scan.

Behaviour:
- Reset: clear=1 at an edge sets an=4'b1111, seg=7'h7F, dp=1, frame_done=0. It also clears div_cnt and all snapshot registers, sets pos=3, warn_cnt=0, blink_cnt=0, blink_ph=0. Clear mid-frame aborts the frame with no frame_done pulse.
- Scan timing:
  - div_cnt counts 0..REFRESH_DIV-1.
  - At the terminal count, div_cnt returns to 0 and pos decrements 3→2→1→0→3.
  - The 0→3 wrap asserts frame_done for exactly that one cycle. Frame period is 4*REFRESH_DIV cycles.
- Snapshot: on the frame_done cycle, all four 8-bit fields are registered. Input changes at any other time have no visible effect until the next frame.
- Outputs are registered, with one cycle of latency from the pos/snapshot state:
  - an = ~(4'b0001 << pos).
  - seg = decode(snap[pos]).
  - dp = 0 only when pos==2 (separator between the digit pair and the count pair); otherwise 1.
- Decode:
  - If field[7:4]==0, seg shows hex field[3:0] in standard glyphs: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 5=7'h12, 7=7'h78, 8=7'h00, 9=7'h10, B=7'h03, D=7'h21, others standard.
  - If field[7:4]!=0 (out of range), seg=7'h3F (dash).
- Warning hold:
  - Any cycle with warning=1 reloads warn_cnt=WARN_HOLD. Reload has priority over decrement.
  - Otherwise warn_cnt decrements on frame_done when nonzero.
- Blink:
  - While warn_cnt≠0, blink_cnt counts frames 0..BLINK_DIV-1.
  - At its terminal count, blink_ph toggles.
  - When warn_cnt==0, blink_cnt=0 and blink_ph=0, so each blink sequence starts in the visible phase.
- Blanking: blank=(warn_cnt≠0)&&blink_ph. While blank, an=4'b1111, seg=7'h7F, dp=1. Scan counters and snapshot keep running.
- Simultaneous events on one edge:
  - frame_done with warning=1: reload wins.
  - frame_done with blink terminal count: the snapshot and the blink toggle both take effect.

Decomposition:
- Shared package lab3_disp_pkg holds:
  - segment constants: SEG_BLANK=7'h7F, SEG_DASH=7'h3F, 16-entry hex glyph table;
  - position indices POS_DIGIT1..POS_COUNT0 = 3..0;
  - the DP_POS=2 constant.
- One combinational sub-module, lab3_seg_decode (8-bit field in → 7-bit seg out, including the dash rule), shared with any future display blocks.
- Counters and blink/warn logic stay in lab3_seg_scan.

Test Plan:
- Reset: hold clear 3 cycles, then release → an=1111, seg=7'h7F, dp=1, frame_done=0 while clear is high. First frame_done occurs 16 cycles after release (defaults).
- Scan order: inputs 8'h0D/8'h02/8'h03/8'h07 on digit1/digit0/count1/count0 are captured at the first frame_done. In the following frame:
  - an steps 0111,1011,1101,1110, each held 4 cycles;
  - seg shows 7'h21, 7'h24, 7'h30, 7'h78;
  - dp=0 only at an=1011.
- Snapshot: change digit1 to 8'h05 mid-frame → position 3 keeps showing 7'h21 until the frame after the next frame_done, then shows 7'h12.
- Out of range: count0=8'h1A → position 0 shows 7'h3F.
- Warning: a single 1-cycle warning pulse gives:
  - 2 frames visible, then 2 frames blanked (an=1111), alternating;
  - blinking continues for 8 frames after the pulse;
  - normal display resumes with blink_ph=0.
  - A second pulse during the hold restarts the 8-frame count.
- Clear mid-operation: assert clear during blanking with warn_cnt=5 → next cycle shows the reset outputs. After release, the display is visible, shows zeros (7'h40) after the first frame, and does not blink.
